// File: rtl/u409_cia_if.sv
// Bus bundle between the address decode / bus FSM and the CIA cycle generator.
interface u409_cia_if;
    logic ts;
    logic cia_space;
    logic rnw;
    logic e;
    logic cia_enable;
    logic cia_rnw;
    logic dle;
    logic tack;
    logic busy;

    // Decode / bus FSM side: issues requests, observes the CIA timing outputs.
    modport master (
        output ts, cia_space, rnw,
        input  e, cia_enable, cia_rnw, dle, tack, busy
    );

    // Cycle generator side.
    modport slave (
        input  ts, cia_space, rnw,
        output e, cia_enable, cia_rnw, dle, tack, busy
    );
endinterface

// File: rtl/u409_cia_cycle.sv
// 8520 CIA bus-cycle generator: free-running E clock divider plus an access
// sequencer that aligns each CPU request to a full E period.
module u409_cia_cycle #(
    parameter int unsigned E_LOW  = 21,
    parameter int unsigned E_HIGH = 14
) (
    input  logic        bclk_i,
    input  logic        reset_i,
    u409_cia_if.slave   cia_io
);

    localparam int unsigned P  = E_LOW + E_HIGH;
    localparam int unsigned CW = $clog2(P);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    state_t        state_q;
    logic [CW-1:0] ecnt_q;
    logic [CW-1:0] ecnt_d;
    logic          last_c;
    logic          e_q;
    logic          e_d;
    logic          cia_enable_q;
    logic          cia_rnw_q;
    logic          dle_q;
    logic          tack_q;
    logic          busy_q;

    // Next E-counter value; E is registered from it so E tracks ECNT exactly.
    always_comb begin
        last_c = (ecnt_q == CW'(P - 1));
        ecnt_d = last_c ? '0 : ecnt_q + CW'(1);
        e_d    = (ecnt_d >= CW'(E_LOW));
    end

    // E generator and access sequencer; every output is a flop.
    always_ff @(posedge bclk_i) begin
        if (reset_i) begin
            ecnt_q       <= '0;
            e_q          <= 1'b0;
            state_q      <= ST_IDLE;
            cia_enable_q <= 1'b0;
            cia_rnw_q    <= 1'b1;
            dle_q        <= 1'b0;
            tack_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            ecnt_q <= ecnt_d;
            e_q    <= e_d;
            dle_q  <= 1'b0;
            tack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // A request in the LAST cycle still waits a whole period.
                    if (cia_io.ts && cia_io.cia_space) begin
                        state_q   <= ST_ARMED;
                        cia_rnw_q <= cia_io.rnw;
                        busy_q    <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (last_c) begin
                        state_q      <= ST_ACTIVE;
                        cia_enable_q <= 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    // Read data is latched in the final E-high cycle.
                    if (cia_rnw_q && (ecnt_q == CW'(P - 2))) begin
                        dle_q <= 1'b1;
                    end
                    if (last_c) begin
                        state_q      <= ST_ACK;
                        cia_enable_q <= 1'b0;
                        cia_rnw_q    <= 1'b1;
                        tack_q       <= 1'b1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cia_io.e          = e_q;
    assign cia_io.cia_enable = cia_enable_q;
    assign cia_io.cia_rnw    = cia_rnw_q;
    assign cia_io.dle        = dle_q;
    assign cia_io.tack       = tack_q;
    assign cia_io.busy       = busy_q;

endmodule
